// File: rtl/dac_wave_gen.sv
// Waveform source for the 8-bit DAC: sawtooth/triangle/square/DC with programmable
// amplitude, floor and phase step; new settings take effect on a period wrap.
module dac_wave_gen #(
  parameter int unsigned CLK_DIV = 250,
  parameter int unsigned DW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          load,
  input  logic [1:0]    wave_sel,
  input  logic [DW-1:0] vpp_set,
  input  logic [DW-1:0] offset_set,
  input  logic [DW-1:0] step_set,
  output logic [DW-1:0] dac_out,
  output logic          dac_wr,
  output logic          period_start
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q;
  logic [DW-1:0]   phase_q;
  logic            smp_q, wrap_q;
  logic            pend_vld_q;
  logic [1:0]      wave_pend_q, wave_act_q;
  logic [DW-1:0]   vpp_pend_q, off_pend_q, step_pend_q;
  logic [DW-1:0]   vpp_act_q, off_act_q, step_act_q;

  logic            tick, wrap, apply;
  logic [DW:0]     phase_sum;
  logic [DW-1:0]   shape, scaled;
  logic [2*DW-1:0] prod;
  logic [DW:0]     level;

  always_comb begin
    tick      = en && (cnt_q == CntMax);
    phase_sum = {1'b0, phase_q} + {1'b0, step_act_q};
    wrap      = tick && phase_sum[DW];
    // While stopped there is no wrap to wait for, so pending settings apply at once.
    apply     = pend_vld_q && (en ? wrap : 1'b1);
  end

  always_comb begin
    shape = '0;
    case (wave_act_q)
      2'd0:    shape = phase_q;
      2'd1:    shape = phase_q[DW-1] ? {~phase_q[DW-2:0], 1'b0} : {phase_q[DW-2:0], 1'b0};
      2'd2:    shape = {DW{phase_q[DW-1]}};
      default: shape = '0;
    endcase
    prod   = {{DW{1'b0}}, shape} * {{DW{1'b0}}, vpp_act_q};
    // Full-scale shape maps to exactly vpp so the square wave hits its amplitude.
    scaled = (&shape) ? vpp_act_q : DW'(prod >> DW);
    level  = {1'b0, off_act_q} + {1'b0, scaled};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      phase_q      <= '0;
      smp_q        <= 1'b0;
      wrap_q       <= 1'b0;
      pend_vld_q   <= 1'b0;
      wave_pend_q  <= '0;
      vpp_pend_q   <= '0;
      off_pend_q   <= '0;
      step_pend_q  <= '0;
      wave_act_q   <= '0;
      vpp_act_q    <= '0;
      off_act_q    <= '0;
      step_act_q   <= DW'(1);
      dac_out      <= '0;
      dac_wr       <= 1'b0;
      period_start <= 1'b0;
    end else begin
      if (!en || tick) cnt_q <= '0;
      else             cnt_q <= cnt_q + CntW'(1);

      if (!en)       phase_q <= '0;
      else if (tick) phase_q <= phase_sum[DW-1:0];

      smp_q  <= tick;
      wrap_q <= wrap;

      if (apply) begin
        wave_act_q <= wave_pend_q;
        vpp_act_q  <= vpp_pend_q;
        off_act_q  <= off_pend_q;
        step_act_q <= step_pend_q;
      end

      if (load) begin
        wave_pend_q <= wave_sel;
        vpp_pend_q  <= vpp_set;
        off_pend_q  <= offset_set;
        step_pend_q <= step_set;
        pend_vld_q  <= 1'b1;
      end else if (apply) begin
        pend_vld_q  <= 1'b0;
      end

      dac_wr       <= smp_q;
      period_start <= wrap_q;
      if (smp_q) dac_out <= level[DW] ? '1 : level[DW-1:0];
    end
  end

endmodule

// File: tb/tb_dac_wave_gen.sv
// Randomized and directed bench for dac_wave_gen against a tick-level behavioural model.
module tb_dac_wave_gen;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n, en, load;
  logic [1:0] wave_sel;
  logic [7:0] vpp_set, offset_set, step_set;
  logic [7:0] dac_out;
  logic       dac_wr, period_start;

  dac_wave_gen #(.CLK_DIV(DIV), .DW(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .load         (load),
    .wave_sel     (wave_sel),
    .vpp_set      (vpp_set),
    .offset_set   (offset_set),
    .step_set     (step_set),
    .dac_out      (dac_out),
    .dac_wr       (dac_wr),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state: tick counter, phase, active/pending settings, sample due next edge.
  int m_cnt, m_phase, m_wave, m_vpp, m_off, m_step;
  int p_wave, p_vpp, p_off, p_step;
  bit p_vld, m_due, m_wrap_due;
  int e_out;
  bit e_wr, e_ps;
  int got_q[$];
  int ps_q[$];

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_sample(input int wave, input int p, input int vpp, input int off);
    int s, sc, sum;
    case (wave)
      0:       s = p;
      1:       s = (p < 128) ? 2 * p : 2 * (255 - p);
      2:       s = (p >= 128) ? 255 : 0;
      default: s = 0;
    endcase
    sc  = (s == 255) ? vpp : (s * vpp) / 256;
    sum = off + sc;
    return (sum > 255) ? 255 : sum;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_phase = 0; m_wave = 0; m_vpp = 0; m_off = 0; m_step = 1;
    p_vld = 0; m_due = 0; m_wrap_due = 0;
    e_out = 0; e_wr = 0; e_ps = 0;
  endtask

  // One clock: advance the model with the inputs present at the edge, then check outputs.
  task automatic step();
    bit tick, wrap, apply;
    int nxt;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      e_wr = m_due;
      e_ps = m_due && m_wrap_due;
      if (m_due) e_out = ref_sample(m_wave, m_phase, m_vpp, m_off);
      tick = en && (m_cnt == DIV - 1);
      wrap = 0;
      m_cnt = en ? (m_cnt + 1) % DIV : 0;
      if (!en) m_phase = 0;
      else if (tick) begin
        nxt = m_phase + m_step;
        wrap = (nxt >= 256);
        m_phase = nxt % 256;
      end
      apply = p_vld && (en ? wrap : 1'b1);
      if (apply) begin
        m_wave = p_wave; m_vpp = p_vpp; m_off = p_off; m_step = p_step;
      end
      if (load) begin
        p_wave = wave_sel; p_vpp = vpp_set; p_off = offset_set; p_step = step_set; p_vld = 1;
      end else if (apply) begin
        p_vld = 0;
      end
      m_due = tick;
      m_wrap_due = wrap;
    end
    @(negedge clk);
    check_eq("dac_wr", dac_wr, e_wr);
    check_eq("period_start", period_start, e_ps);
    check_eq("dac_out", dac_out, e_out);
    if (dac_wr) begin
      got_q.push_back(dac_out);
      ps_q.push_back(period_start);
    end
  endtask

  task automatic wait_samples(input int n);
    got_q.delete();
    ps_q.delete();
    for (int i = 0; i < n * DIV + 8 && got_q.size() < n; i++) step();
    check_eq("sample_count", got_q.size(), n);
    while (got_q.size() < n) begin
      got_q.push_back(-1);
      ps_q.push_back(-1);
    end
  endtask

  task automatic load_cfg(input int w, input int v, input int o, input int s);
    wave_sel = 2'(w); vpp_set = 8'(v); offset_set = 8'(o); step_set = 8'(s);
    load = 1'b1;
    step();
    load = 1'b0;
    step();
  endtask

  initial begin
    int exp_sq[4] = '{220, 20, 220, 20};
    int exp_tri[4] = '{127, 253, 125, 0};
    model_reset();
    rst_n = 1'b0; en = 1'b1; load = 1'b1;
    wave_sel = 2'd2; vpp_set = 8'd99; offset_set = 8'd77; step_set = 8'd5;

    // Reset held with en and load active
    repeat (3) step();
    check_eq("rst_dac_out", dac_out, 0);
    check_eq("rst_dac_wr", dac_wr, 0);
    check_eq("rst_period_start", period_start, 0);
    rst_n = 1'b1; load = 1'b0;
    wait_samples(3);
    for (int i = 0; i < 3; i++) check_eq("post_rst_zero", got_q[i], 0);

    // Square wave, Vpp 200 above a floor of 20
    en = 1'b0;
    load_cfg(2, 200, 20, 128);
    en = 1'b1;
    wait_samples(4);
    for (int i = 0; i < 4; i++) begin
      check_eq("square_out", got_q[i], exp_sq[i]);
      check_eq("square_ps", ps_q[i], i % 2);
    end

    // Saturation
    en = 1'b0;
    load_cfg(2, 255, 100, 128);
    en = 1'b1;
    wait_samples(2);
    check_eq("sat_high", got_q[0], 255);
    check_eq("sat_low", got_q[1], 100);

    // Triangle
    en = 1'b0;
    load_cfg(1, 255, 0, 64);
    en = 1'b1;
    wait_samples(4);
    for (int i = 0; i < 4; i++) check_eq("tri_out", got_q[i], exp_tri[i]);
    check_eq("tri_ps_mid", ps_q[2], 0);
    check_eq("tri_ps_wrap", ps_q[3], 1);

    // Deferred load: takes effect only at the wrap
    en = 1'b0;
    load_cfg(0, 128, 0, 16);
    en = 1'b1;
    wait_samples(3);
    check_eq("saw_48", got_q[2], 24);
    vpp_set = 8'd64;
    load = 1'b1;
    step();
    load = 1'b0;
    wait_samples(14);
    check_eq("defer_old_vpp", got_q[11], 120);
    check_eq("defer_wrap_ps", ps_q[12], 1);
    check_eq("defer_wrap_out", got_q[12], 0);
    check_eq("defer_new_vpp", got_q[13], 4);

    // Reset with a pending load: pending must never reach the output
    wave_sel = 2'd2; vpp_set = 8'd200; offset_set = 8'd50; step_set = 8'd1;
    load = 1'b1;
    step();
    load = 1'b0;
    rst_n = 1'b0;
    repeat (2) step();
    check_eq("midrst_wr", dac_wr, 0);
    rst_n = 1'b1;
    wait_samples(258);
    check_eq("midrst_wrap_ps", ps_q[255], 1);
    check_eq("midrst_after_wrap0", got_q[256], 0);
    check_eq("midrst_after_wrap1", got_q[257], 0);

    // Randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 600; i++) begin
      rst_n      = ($urandom_range(63) != 0);
      en         = ($urandom_range(7) != 0);
      load       = ($urandom_range(11) == 0);
      wave_sel   = 2'($urandom_range(3));
      vpp_set    = 8'($urandom_range(255));
      offset_set = 8'($urandom_range(255));
      step_set   = 8'($urandom_range(255));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
